// File: rtl/adc733_pkg.sv
// Shared types and helpers for the AD73360 per-channel block averager.
package adc733_pkg;

    localparam int CH_W      = 3;
    localparam int DATA_W    = 16;
    // Widest accumulator needed (AVG_LOG2 up to 4).
    localparam int SUM_W_MAX = DATA_W + 4;

    // One output word: the channel tag and its averaged sample.
    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } fifo_word_t;

    // Sample-handling FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Sign-extend a two's complement sample to the widest accumulator width;
    // callers size-cast down to their own accumulator width.
    function automatic logic [SUM_W_MAX-1:0] sext_sample(input logic [DATA_W-1:0] v);
        return {{(SUM_W_MAX-DATA_W){v[DATA_W-1]}}, v};
    endfunction

endpackage

// File: rtl/adc733_sync_fifo.sv
// Small show-ahead synchronous FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module adc733_sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign fill_o  = count_q;
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    // Head word is presented directly; zero while empty so reset shows 0.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array: written on accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/adc733_chan_avg.sv
// Per-channel block averager behind the AD73360 serial-port wrapper.
// Detects sample strobes, accumulates 2^AVG_LOG2 samples per channel and
// queues {channel, average} words for a valid/ready consumer.
module adc733_chan_avg
    import adc733_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_en_i,
    input  logic                          op_mode_i,
    input  logic [CH_W-1:0]               channel_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic [CH_W-1:0]               m_channel,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] AVG_N    = CNT_W'(1 << AVG_LOG2);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic              rd_s1_q, rd_s2_q, rd_s3_q;
    logic              evt;
    logic              opm_q;
    logic              clr_all_q;
    state_t            state_q, state_d;
    logic              capture;
    logic [CH_W-1:0]   ch_q;
    logic [DATA_W-1:0] sample_q;
    logic [SUM_W-1:0]  sample_ext;
    logic [SUM_W-1:0]  sum_arr [NUM_CH];
    logic [CNT_W-1:0]  cnt_arr [NUM_CH];
    logic [SUM_W-1:0]  cur_sum;
    logic [CNT_W-1:0]  cur_cnt;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    fifo_word_t        push_word;
    fifo_word_t        head_word;
    logic              overflow_q;

    // Two-flop synchroniser plus edge register on the asynchronous strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_s1_q <= 1'b0;
            rd_s2_q <= 1'b0;
            rd_s3_q <= 1'b0;
        end else begin
            rd_s1_q <= rd_en_i;
            rd_s2_q <= rd_s1_q;
            rd_s3_q <= rd_s2_q;
        end
    end

    assign evt = rd_s2_q & ~rd_s3_q;

    // Registered op_mode falling-edge detect; clears all partial blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            opm_q     <= 1'b0;
            clr_all_q <= 1'b0;
        end else begin
            opm_q     <= op_mode_i;
            clr_all_q <= opm_q & ~op_mode_i;
        end
    end

    // FSM state register plus the sample/channel captured on the event cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            sample_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                ch_q     <= channel_i;
                sample_q <= data_i;
            end
        end
    end

    // Next-state logic; events outside IDLE are silently lost.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt && op_mode_i && ({1'b0, channel_i} < NUM_CH_L)) begin
                    state_d = ACC;
                    capture = 1'b1;
                end
            end
            ACC: begin
                state_d = ((cur_cnt + CNT_W'(1)) == AVG_N) ? EMIT : IDLE;
            end
            EMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sample_ext = SUM_W'(sext_sample(sample_q));

    // Per-channel accumulator and sample count.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_acc
        logic [SUM_W-1:0] sum_q;
        logic [CNT_W-1:0] cnt_q;

        // Accumulate in ACC, clear after EMIT or on an op_mode drop.
        always_ff @(posedge clk) begin
            if (rst || clr_all_q) begin
                sum_q <= '0;
                cnt_q <= '0;
            end else if (ch_q == CH_W'(gi)) begin
                if (state_q == ACC) begin
                    sum_q <= sum_q + sample_ext;
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if (state_q == EMIT) begin
                    sum_q <= '0;
                    cnt_q <= '0;
                end
            end
        end

        assign sum_arr[gi] = sum_q;
        assign cnt_arr[gi] = cnt_q;
    end

    // Select the accumulator of the channel currently being processed.
    always_comb begin
        cur_sum = '0;
        cur_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                cur_sum = sum_arr[i];
                cur_cnt = cnt_arr[i];
            end
        end
    end

    // Floor average via arithmetic shift of the completed sum.
    assign push           = (state_q == EMIT);
    assign push_word.ch   = ch_q;
    assign push_word.data = DATA_W'($signed(cur_sum) >>> AVG_LOG2);

    assign pop = m_valid & m_ready;

    adc733_sync_fifo #(
        .WIDTH ($bits(fifo_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_word),
        .pop_i   (pop),
        .data_o  (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fill)
    );

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end else if (clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow  = overflow_q;
    assign m_valid   = ~fifo_empty;
    assign m_data    = head_word.data;
    assign m_channel = head_word.ch;

endmodule

// File: tb/tb_adc733_chan_avg.sv
// Directed bench for the per-channel block averager (NUM_CH=6, AVG_LOG2=2,
// FIFO_DEPTH=8). Expected words are hand-computed.
module tb_adc733_chan_avg;

    logic        clk;
    logic        rst;
    logic        rd_en_i;
    logic        op_mode_i;
    logic [2:0]  channel_i;
    logic [15:0] data_i;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [2:0]  m_channel;
    logic        overflow;
    logic        clr_ovf;
    logic [3:0]  fill;

    int n_vec = 0;
    int n_err = 0;

    adc733_chan_avg #(
        .NUM_CH     (6),
        .AVG_LOG2   (2),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en_i   (rd_en_i),
        .op_mode_i (op_mode_i),
        .channel_i (channel_i),
        .data_i    (data_i),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_channel (m_channel),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .fill      (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One strobe: rd_en high for 3 cycles, low for 3+. Cycle i counts posedges
    // after the rise; the event cycle follows posedge 2, EMIT follows posedge 4,
    // the word lands at posedge 5.
    // mode 1: latency check; mode 2: pop the head in the same cycle as the push.
    task automatic strobe(input logic [2:0] ch, input logic [15:0] d,
                          input logic opm, input int mode);
        @(negedge clk);
        channel_i = ch;
        data_i    = d;
        op_mode_i = opm;
        rd_en_i   = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 3) rd_en_i = 1'b0;
            if (mode == 1 && i == 4) chk("lat_valid_before", m_valid, 0);
            if (mode == 1 && i == 5) chk("lat_valid_at_e3", m_valid, 1);
            if (mode == 2 && i == 4) begin
                chk("full_head_data", m_data, 16'h0010);
                chk("full_head_ch", m_channel, 1);
                chk("full_fill_pre", fill, 8);
                m_ready = 1'b1;
            end
            if (mode == 2 && i == 5) begin
                m_ready = 1'b0;
                chk("pushpop_fill", fill, 8);
                chk("pushpop_no_ovf", overflow, 0);
            end
        end
    endtask

    task automatic pop_expect(input string tag, input logic [2:0] ch, input logic [15:0] d);
        int waited;
        waited = 0;
        while (!m_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, m_valid, 1);
        chk({tag, "_ch"}, m_channel, ch);
        chk({tag, "_data"}, m_data, d);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic expect_empty(input string tag);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_fill"}, fill, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rd_en_i   = 1'b0;
        op_mode_i = 1'b1;
        channel_i = '0;
        data_i    = '0;
        m_ready   = 1'b0;
        clr_ovf   = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ch", m_channel, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_fill", fill, 0);

        // Basic average on ch2: (0x10+0x20+0x30+0x40)/4 = 0x28
        strobe(3'd2, 16'h0010, 1'b1, 0);
        strobe(3'd2, 16'h0020, 1'b1, 0);
        strobe(3'd2, 16'h0030, 1'b1, 0);
        strobe(3'd2, 16'h0040, 1'b1, 1);
        chk("basic_fill", fill, 1);
        pop_expect("basic", 3'd2, 16'h0028);
        expect_empty("basic_after");

        // Negative: sum -6, floor(-1.5) = -2
        strobe(3'd5, 16'hFFFF, 1'b1, 0);
        strobe(3'd5, 16'hFFFE, 1'b1, 0);
        strobe(3'd5, 16'hFFFF, 1'b1, 0);
        strobe(3'd5, 16'hFFFE, 1'b1, 0);
        pop_expect("neg", 3'd5, 16'hFFFE);

        // Interleaved ch0/ch1
        for (int k = 0; k < 8; k++) begin
            strobe(3'(k % 2), 16'((k % 2) * 100), 1'b1, 0);
        end
        pop_expect("ilv0", 3'd0, 16'd0);
        pop_expect("ilv1", 3'd1, 16'd100);
        expect_empty("ilv_after");

        // op_mode 0 strobes are dropped
        for (int k = 0; k < 4; k++) strobe(3'd0, 16'h1234, 1'b0, 0);
        expect_empty("opm0");
        // channel 7 >= NUM_CH is dropped
        for (int k = 0; k < 4; k++) strobe(3'd7, 16'h1234, 1'b1, 0);
        expect_empty("ch7");

        // Partial block discarded by op_mode toggle
        strobe(3'd3, 16'h1000, 1'b1, 0);
        strobe(3'd3, 16'h1000, 1'b1, 0);
        @(negedge clk);
        op_mode_i = 1'b0;
        repeat (3) @(negedge clk);
        op_mode_i = 1'b1;
        repeat (3) @(negedge clk);
        strobe(3'd3, 16'h0008, 1'b1, 0);
        strobe(3'd3, 16'h0010, 1'b1, 0);
        strobe(3'd3, 16'h0018, 1'b1, 0);
        strobe(3'd3, 16'h0020, 1'b1, 0);
        pop_expect("opm_clr", 3'd3, 16'h0014);
        expect_empty("opm_clr_after");

        // Backpressure: 9 averages into an 8-deep FIFO; word k = {k%6, k*16}
        for (int k = 1; k <= 9; k++) begin
            for (int s = 0; s < 4; s++) strobe(3'(k % 6), 16'(k * 16), 1'b1, 0);
        end
        chk("bp_fill", fill, 8);
        chk("bp_ovf", overflow, 1);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);

        // 10th average pushed while popping at full
        for (int s = 0; s < 3; s++) strobe(3'd4, 16'd160, 1'b1, 0);
        strobe(3'd4, 16'd160, 1'b1, 2);
        for (int k = 2; k <= 8; k++) begin
            pop_expect($sformatf("drain%0d", k), 3'(k % 6), 16'(k * 16));
        end
        pop_expect("drain10", 3'd4, 16'd160);
        expect_empty("drain_after");

        // Reset in the middle of a block
        strobe(3'd4, 16'h0800, 1'b1, 0);
        strobe(3'd4, 16'h0800, 1'b1, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) strobe(3'd4, 16'h0100, 1'b1, 0);
        pop_expect("midrst", 3'd4, 16'h0100);
        expect_empty("midrst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
